// File: rtl/fifo_burst_consumer_pkg.sv
// rtl/fifo_burst_consumer_pkg.sv - shared word type and FSM encoding for the burst consumer
package fifo_burst_consumer_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_burst_consumer_accum.sv
// rtl/fifo_burst_consumer_accum.sv - 33-bit burst accumulator step with carry-out
module fifo_burst_consumer_accum
   import fifo_burst_consumer_pkg::*;
(
   input  word_t sum,
   input  word_t word,
   output word_t sum_next,
   output logic  carry
);

   logic [32:0] wide;

   assign wide     = {1'b0, sum} + {1'b0, word};
   assign sum_next = wide[31:0];
   assign carry    = wide[32];

endmodule

// File: rtl/fifo_burst_consumer.sv
// rtl/fifo_burst_consumer.sv - drains BURST_LEN words from a FIFO and enqueues their sum downstream
module fifo_burst_consumer
   import fifo_burst_consumer_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_first__RDY,
   input  logic [31:0]      in_first,
   input  logic             in_deq__RDY,
   output logic             in_deq__ENA,
   input  logic             out_enq__RDY,
   output logic             out_enq__ENA,
   output logic [31:0]      out_enq_v,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] words_total
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] idx;
   word_t            sum, result, sum_add;
   logic             carry, take, last;

   fifo_burst_consumer_accum u_accum (
      .sum      (sum),
      .word     (in_first),
      .sum_next (sum_add),
      .carry    (carry)
   );

   assign last = (idx == CNT_W'(BURST_LEN - 1));

   // nRST gates both calls so no method fires while the block is being reset
   always_comb begin
      state_nxt    = state;
      take         = 1'b0;
      in_deq__ENA  = 1'b0;
      out_enq__ENA = 1'b0;
      case (state)
         ST_ACCUM: begin
            take        = in_first__RDY & in_deq__RDY & nRST;
            in_deq__ENA = take;
            if (take && last) state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            out_enq__ENA = out_enq__RDY & nRST;
            if (out_enq__ENA) state_nxt = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= ST_ACCUM;
         sum         <= '0;
         idx         <= '0;
         result      <= '0;
         overflow    <= 1'b0;
         words_total <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            words_total <= words_total + CNT_W'(1);
            if (carry) overflow <= 1'b1;
            if (last) begin
               result <= sum_add;
               sum    <= '0;
               idx    <= '0;
            end else begin
               sum <= sum_add;
               idx <= idx + CNT_W'(1);
            end
         end
      end
   end

   assign out_enq_v = result;
   assign busy      = (state == ST_EMIT) | (idx != '0);

endmodule

// File: tb/tb_fifo_burst_consumer.sv
// tb/tb_fifo_burst_consumer.sv - scoreboard bench for burst lengths 4 and 1
module tb_fifo_burst_consumer;

   localparam int BL0 = 4;
   localparam int BL1 = 1;

   logic        CLK  = 1'b0;
   logic        nRST = 1'b0;
   logic [1:0]  first_rdy, deq_rdy, deq_ena, enq_rdy, enq_ena, busy, ovf;
   logic [31:0] first_w [2];
   logic [31:0] enq_v   [2];
   logic [15:0] wt      [2];

   logic [31:0] src  [2][$];
   logic [31:0] cons [2][$];
   logic [31:0] expq [2][$];
   bit          m_ovf  [2];
   logic [15:0] m_tot  [2];
   logic [31:0] last_v [2];
   int          n_push [2] = '{0, 0};
   int          n_enq  [2] = '{0, 0};
   int          up_pct [2] = '{100, 100};
   int          dn_pct [2] = '{100, 100};
   int          total = 0;
   int          bad   = 0;
   longint unsigned s;
   bit          pend;

   always #5 CLK = ~CLK;

   fifo_burst_consumer #(.BURST_LEN(BL0), .CNT_W(16)) u_dut0 (
      .CLK(CLK), .nRST(nRST),
      .in_first__RDY(first_rdy[0]), .in_first(first_w[0]),
      .in_deq__RDY(deq_rdy[0]), .in_deq__ENA(deq_ena[0]),
      .out_enq__RDY(enq_rdy[0]), .out_enq__ENA(enq_ena[0]), .out_enq_v(enq_v[0]),
      .busy(busy[0]), .overflow(ovf[0]), .words_total(wt[0])
   );

   fifo_burst_consumer #(.BURST_LEN(BL1), .CNT_W(16)) u_dut1 (
      .CLK(CLK), .nRST(nRST),
      .in_first__RDY(first_rdy[1]), .in_first(first_w[1]),
      .in_deq__RDY(deq_rdy[1]), .in_deq__ENA(deq_ena[1]),
      .out_enq__RDY(enq_rdy[1]), .out_enq__ENA(enq_ena[1]), .out_enq_v(enq_v[1]),
      .busy(busy[1]), .overflow(ovf[1]), .words_total(wt[1])
   );

   function automatic int bl(input int k);
      return (k == 0) ? BL0 : BL1;
   endfunction

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", name, k, $time, act, exp);
      end
   endtask

   // upstream FIFO and downstream FIFO models drive inputs just after each edge
   always @(posedge CLK) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         first_rdy[k] = (src[k].size() != 0) && ($urandom_range(0, 99) < up_pct[k]);
         deq_rdy[k]   = (src[k].size() != 0) && ($urandom_range(0, 99) < up_pct[k]);
         first_w[k]   = (src[k].size() != 0) ? src[k][0] : $urandom();
         enq_rdy[k]   = ($urandom_range(0, 99) < dn_pct[k]);
      end
   end

   // monitor: compare against the reference, then record what the coming edge commits
   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         pend = (expq[k].size() != 0);
         chk("words_total", k, wt[k], m_tot[k]);
         chk("overflow", k, ovf[k], m_ovf[k]);
         chk("busy", k, busy[k], pend || (cons[k].size() != 0));
         chk("deq_ena", k, deq_ena[k], nRST && !pend && first_rdy[k] && deq_rdy[k]);
         chk("enq_ena", k, enq_ena[k], nRST && pend && enq_rdy[k]);
         if (pend) chk("enq_v", k, enq_v[k], expq[k][0]);
         if (!nRST) begin
            cons[k].delete();
            expq[k].delete();
            m_ovf[k] = 1'b0;
            m_tot[k] = '0;
         end else begin
            if (enq_ena[k] && pend) begin
               last_v[k] = enq_v[k];
               void'(expq[k].pop_front());
               n_enq[k]++;
            end
            if (deq_ena[k] && src[k].size() != 0) begin
               cons[k].push_back(src[k].pop_front());
               m_tot[k] = m_tot[k] + 16'd1;
               s = 0;
               for (int i = 0; i < cons[k].size(); i++) s += cons[k][i];
               if (s >= 64'h1_0000_0000) m_ovf[k] = 1'b1;
               if (cons[k].size() == bl(k)) begin
                  expq[k].push_back(s[31:0]);
                  n_push[k]++;
                  cons[k].delete();
               end
            end
         end
      end
   end

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((src[0].size() + src[1].size() + expq[0].size() + expq[1].size()) != 0 && n < lim) begin
         @(negedge CLK);
         n++;
      end
      chk("idle_in_time", 0, n < lim, 1);
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nb;
      int enq_before;
      m_ovf  = '{0, 0};
      m_tot  = '{16'd0, 16'd0};
      last_v = '{32'd0, 32'd0};
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         chk("rst_enq_v", k, enq_v[k], 0);
         chk("rst_busy", k, busy[k], 0);
         chk("rst_ovf", k, ovf[k], 0);
         chk("rst_words", k, wt[k], 0);
      end

      src[0].push_back(1); src[0].push_back(2); src[0].push_back(3); src[0].push_back(4);
      src[1].push_back(3); src[1].push_back(6); src[1].push_back(9);
      wait_idle(100);
      chk("burst_1234", 0, last_v[0], 10);
      chk("bl1_last", 1, last_v[1], 9);
      chk("bl1_count", 1, n_enq[1], 3);

      dn_pct[0] = 0;
      repeat (4) src[0].push_back(5);
      repeat (10) @(negedge CLK);
      chk("held_pending", 0, expq[0].size(), 1);
      dn_pct[0] = 100;
      wait_idle(100);
      chk("burst_held", 0, last_v[0], 20);

      up_pct[0] = 50;
      src[0].push_back(7); src[0].push_back(8); src[0].push_back(9); src[0].push_back(10);
      wait_idle(200);
      chk("burst_stall", 0, last_v[0], 34);
      up_pct[0] = 100;

      src[0].push_back(32'hFFFF_FFFF); src[0].push_back(1); src[0].push_back(0); src[0].push_back(0);
      wait_idle(100);
      chk("wrap_value", 0, last_v[0], 0);
      chk("wrap_ovf", 0, ovf[0], 1);
      repeat (4) src[0].push_back(1);
      wait_idle(100);
      chk("after_wrap", 0, last_v[0], 4);
      chk("ovf_sticky", 0, ovf[0], 1);

      repeat (4) src[0].push_back(9);
      n = 0;
      @(posedge CLK); #1;
      while (cons[0].size() != 2 && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("two_taken", 0, cons[0].size(), 2);
      nRST = 1'b0;
      src[0].delete();
      enq_before = n_enq[0];
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_busy", 0, busy[0], 0);
      chk("mid_rst_words", 0, wt[0], 0);
      chk("mid_rst_ovf", 0, ovf[0], 0);
      chk("mid_rst_no_enq", 0, n_enq[0], enq_before);
      repeat (4) src[0].push_back(1);
      wait_idle(100);
      chk("post_rst_burst", 0, last_v[0], 4);

      for (int r = 0; r < 10; r++) begin
         up_pct[0] = $urandom_range(30, 100);
         up_pct[1] = $urandom_range(30, 100);
         dn_pct[0] = $urandom_range(20, 100);
         dn_pct[1] = $urandom_range(20, 100);
         nb = $urandom_range(1, 5);
         for (int i = 0; i < nb * BL0; i++)
            src[0].push_back(($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1000)));
         for (int i = 0; i < nb * 2; i++)
            src[1].push_back($urandom());
         wait_idle(2000);
      end

      for (int k = 0; k < 2; k++) chk("enq_total", k, n_enq[k], n_push[k]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
